// File: rtl/ecap5_dproc_pkg.sv
// ============================================================================
// Module      : ecap5_dproc_pkg
// Description : Shared ECAP5-DPROC constants: redirect entry addresses and the
//               fetch PC sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ecap5_dproc_pkg;

    localparam logic [31:0] BOOT_ADDRESS      = 32'h0000_0000;
    localparam logic [31:0] INTERRUPT_ADDRESS = 32'h0000_000A;
    localparam logic [31:0] DEBUG_ADDRESS     = 32'h0000_000B;

    typedef enum logic [1:0] {
        PC_SEQ_RESET = 2'd0,
        PC_SEQ_RUN   = 2'd1,
        PC_SEQ_IRQ   = 2'd2,
        PC_SEQ_DEBUG = 2'd3
    } pc_seq_state_t;

endpackage

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch PC sequencer with branch, interrupt and debug redirects.
//               Debug support is built only when ECAP5_DPROC_DEBUG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
    import ecap5_dproc_pkg::*;
#(
    parameter logic [31:0] PC_STEP = 32'd4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        irq_i,
    input  logic        mret_i,
    input  logic        drq_i,
    input  logic        dret_i,
    output logic [31:0] pc_o,
    output logic        pc_valid_o,
    output logic        irq_ack_o,
    output logic        drq_ack_o,
    output logic [31:0] epc_o,
    output logic [31:0] dpc_o
);

    localparam logic [1:0] C_ST_RESET = PC_SEQ_RESET;
    localparam logic [1:0] C_ST_RUN   = PC_SEQ_RUN;
    localparam logic [1:0] C_ST_IRQ   = PC_SEQ_IRQ;

    logic [1:0]  r_state_q,   w_state_d;
    logic [31:0] r_pc_q,      w_pc_d;
    logic        r_valid_q,   w_valid_d;
    logic [31:0] r_epc_q,     w_epc_d;
    logic        r_irq_ack_q, w_irq_ack_d;
    logic [31:0] w_seq;
    logic        w_advance;

`ifdef ECAP5_DPROC_DEBUG_EN
    localparam logic [1:0] C_ST_DEBUG = PC_SEQ_DEBUG;

    logic [31:0] r_dpc_q,     w_dpc_d;
    logic [1:0]  r_saved_q,   w_saved_d;
    logic        r_drq_ack_q, w_drq_ack_d;
`else
    logic        w_unused_dbg;
    assign w_unused_dbg = ^{drq_i, dret_i, DEBUG_ADDRESS, PC_SEQ_DEBUG};
`endif

    assign w_seq     = branch_i ? branch_target_i : (r_pc_q + PC_STEP);
    assign w_advance = r_valid_q & ~stall_i;

    always_comb begin
        w_state_d   = r_state_q;
        w_pc_d      = r_pc_q;
        w_valid_d   = 1'b1;
        w_epc_d     = r_epc_q;
        w_irq_ack_d = 1'b0;
`ifdef ECAP5_DPROC_DEBUG_EN
        w_dpc_d     = r_dpc_q;
        w_saved_d   = r_saved_q;
        w_drq_ack_d = 1'b0;
`endif
        if (r_state_q == C_ST_RESET) begin
            w_state_d = C_ST_RUN;
            w_pc_d    = BOOT_ADDRESS;
        end else if (w_advance) begin
            // Each redirect is qualified by its state, so a masked request
            // falls through to the next lower priority.
`ifdef ECAP5_DPROC_DEBUG_EN
            if (dret_i && (r_state_q == C_ST_DEBUG)) begin
                w_pc_d    = r_dpc_q;
                w_state_d = r_saved_q;
            end else if (drq_i && (r_state_q != C_ST_DEBUG)) begin
                w_dpc_d     = w_seq;
                w_saved_d   = r_state_q;
                w_pc_d      = DEBUG_ADDRESS;
                w_drq_ack_d = 1'b1;
                w_state_d   = C_ST_DEBUG;
            end else
`endif
            if (mret_i && (r_state_q == C_ST_IRQ)) begin
                w_pc_d    = r_epc_q;
                w_state_d = C_ST_RUN;
            end else if (irq_i && (r_state_q == C_ST_RUN)) begin
                w_epc_d     = w_seq;
                w_pc_d      = INTERRUPT_ADDRESS;
                w_irq_ack_d = 1'b1;
                w_state_d   = C_ST_IRQ;
            end else begin
                w_pc_d = w_seq;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q   <= C_ST_RESET;
            r_pc_q      <= 32'h0;
            r_valid_q   <= 1'b0;
            r_epc_q     <= 32'h0;
            r_irq_ack_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_pc_q      <= w_pc_d;
            r_valid_q   <= w_valid_d;
            r_epc_q     <= w_epc_d;
            r_irq_ack_q <= w_irq_ack_d;
        end
    end

`ifdef ECAP5_DPROC_DEBUG_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_dpc_q     <= 32'h0;
            r_saved_q   <= C_ST_RUN;
            r_drq_ack_q <= 1'b0;
        end else begin
            r_dpc_q     <= w_dpc_d;
            r_saved_q   <= w_saved_d;
            r_drq_ack_q <= w_drq_ack_d;
        end
    end

    assign dpc_o     = r_dpc_q;
    assign drq_ack_o = r_drq_ack_q;
`else
    assign dpc_o     = 32'h0;
    assign drq_ack_o = 1'b0;
`endif

    assign pc_o       = r_pc_q;
    assign pc_valid_o = r_valid_q;
    assign irq_ack_o  = r_irq_ack_q;
    assign epc_o      = r_epc_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer: directed walk-through
//               with literal expectations, then randomized traffic vs a model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

`ifdef ECAP5_DPROC_DEBUG_EN
    localparam bit DBG = 1'b1;
`else
    localparam bit DBG = 1'b0;
`endif

    localparam int M_RESET = 0;
    localparam int M_RUN   = 1;
    localparam int M_IRQ   = 2;
    localparam int M_DEBUG = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] target = 32'h0;
    logic        irq = 1'b0;
    logic        mret = 1'b0;
    logic        drq = 1'b0;
    logic        dret = 1'b0;
    logic [31:0] pc, epc, dpc;
    logic        pc_valid, irq_ack, drq_ack;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // behavioural model state
    logic [31:0] m_pc = 32'h0, m_epc = 32'h0, m_dpc = 32'h0;
    logic        m_valid = 1'b0, m_iack = 1'b0, m_dack = 1'b0;
    int          m_mode = M_RESET;
    int          m_saved = M_RUN;

    pc_sequencer #(.PC_STEP(32'd4)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .stall_i         (stall),
        .branch_i        (branch),
        .branch_target_i (target),
        .irq_i           (irq),
        .mret_i          (mret),
        .drq_i           (drq),
        .dret_i          (dret),
        .pc_o            (pc),
        .pc_valid_o      (pc_valid),
        .irq_ack_o       (irq_ack),
        .drq_ack_o       (drq_ack),
        .epc_o           (epc),
        .dpc_o           (dpc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: applies the documented redirect rules once per rising edge.
    always @(posedge clk) begin
        logic [31:0] seq;
        m_iack = 1'b0;
        m_dack = 1'b0;
        seq = branch ? target : m_pc + 32'd4;
        if (rst) begin
            m_pc = 32'h0; m_epc = 32'h0; m_dpc = 32'h0;
            m_valid = 1'b0; m_mode = M_RESET; m_saved = M_RUN;
        end else if (m_mode == M_RESET) begin
            m_pc = 32'h0; m_valid = 1'b1; m_mode = M_RUN;
        end else if (!stall) begin
            if (DBG && dret && m_mode == M_DEBUG) begin
                m_pc = m_dpc; m_mode = m_saved;
            end else if (DBG && drq && m_mode != M_DEBUG) begin
                m_dpc = seq; m_saved = m_mode; m_pc = 32'hB; m_dack = 1'b1; m_mode = M_DEBUG;
            end else if (mret && m_mode == M_IRQ) begin
                m_pc = m_epc; m_mode = M_RUN;
            end else if (irq && m_mode == M_RUN) begin
                m_epc = seq; m_pc = 32'hA; m_iack = 1'b1; m_mode = M_IRQ;
            end else begin
                m_pc = seq;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("pc",       pc,               m_pc);
            check("pc_valid", {31'h0, pc_valid}, {31'h0, m_valid});
            check("irq_ack",  {31'h0, irq_ack},  {31'h0, m_iack});
            check("drq_ack",  {31'h0, drq_ack},  {31'h0, m_dack});
            check("epc",      epc,              m_epc);
            check("dpc",      dpc,              m_dpc);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b1;
        repeat (3) tick();
        chk_en = 1'b1;
        check("lit_reset_valid", {31'h0, pc_valid}, 32'h0);
        check("lit_reset_pc", pc, 32'h0);
        rst = 1'b0;
        tick(); check("lit_boot_pc", pc, 32'h0);
        check("lit_boot_valid", {31'h0, pc_valid}, 32'h1);
        tick(); check("lit_seq4", pc, 32'h4);
        tick(); check("lit_seq8", pc, 32'h8);

        branch = 1'b1; target = 32'h100;
        tick(); check("lit_branch", pc, 32'h100);
        branch = 1'b0;
        tick(); check("lit_after_branch", pc, 32'h104);

        irq = 1'b1;
        tick(); check("lit_irq_pc", pc, 32'hA);
        check("lit_irq_ack", {31'h0, irq_ack}, 32'h1);
        check("lit_epc", epc, 32'h108);
        tick(); check("lit_irq_masked_ack", {31'h0, irq_ack}, 32'h0);
        check("lit_irq_handler_pc", pc, 32'hE);
        mret = 1'b1;
        tick(); check("lit_mret_pc", pc, 32'h108);
        mret = 1'b0;
        tick(); check("lit_irq_retaken", pc, 32'hA);
        check("lit_irq_retaken_ack", {31'h0, irq_ack}, 32'h1);
        check("lit_epc2", epc, 32'h10C);
        irq = 1'b0; mret = 1'b1;
        tick(); check("lit_mret2", pc, 32'h10C);
        mret = 1'b0;

        if (DBG) begin
            drq = 1'b1; branch = 1'b1; target = 32'h200; irq = 1'b1;
            tick(); check("lit_dbg_pc", pc, 32'hB);
            check("lit_dpc", dpc, 32'h200);
            check("lit_dbg_no_iack", {31'h0, irq_ack}, 32'h0);
            check("lit_dbg_ack", {31'h0, drq_ack}, 32'h1);
            drq = 1'b0; branch = 1'b0;
            tick(); check("lit_dbg_masks_irq", pc, 32'hF);
            dret = 1'b1;
            tick(); check("lit_dret", pc, 32'h200);
            dret = 1'b0;
            tick(); check("lit_irq_after_dret", pc, 32'hA);
            check("lit_epc3", epc, 32'h204);
            irq = 1'b0; mret = 1'b1;
            tick(); check("lit_mret3", pc, 32'h204);
            mret = 1'b0;
        end else begin
            drq = 1'b1;
            tick(); check("lit_nodbg_seq", pc, 32'h110);
            check("lit_nodbg_ack", {31'h0, drq_ack}, 32'h0);
            check("lit_nodbg_dpc", dpc, 32'h0);
            drq = 1'b0;
        end

        branch = 1'b1; target = 32'h20;
        tick(); check("lit_at20", pc, 32'h20);
        stall = 1'b1; target = 32'h300;
        for (int i = 0; i < 3; i++) begin
            tick(); check("lit_stall_hold", pc, 32'h20);
        end
        stall = 1'b0;
        tick(); check("lit_stall_release", pc, 32'h300);
        branch = 1'b0;

        irq = 1'b1;
        tick(); check("lit_irq_before_rst", pc, 32'hA);
        irq = 1'b0; rst = 1'b1;
        tick(); check("lit_rst_pc", pc, 32'h0);
        check("lit_rst_valid", {31'h0, pc_valid}, 32'h0);
        check("lit_rst_epc", epc, 32'h0);
        rst = 1'b0;
        tick(); check("lit_reboot", pc, 32'h0);
        tick(); check("lit_reboot_seq", pc, 32'h4);

        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 199) == 0);
            stall  = ($urandom_range(0, 3) == 0);
            branch = ($urandom_range(0, 7) == 0);
            target = $urandom;
            irq    = ($urandom_range(0, 5) == 0);
            mret   = ($urandom_range(0, 7) == 0);
            drq    = ($urandom_range(0, 15) == 0);
            dret   = ($urandom_range(0, 7) == 0);
            tick();
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the ECAP5-DPROC fetch stage. Owns the architectural fetch PC and decides each cycle whether fetch proceeds sequentially, follows a branch, or is redirected to the boot, interrupt or debug entry address. Saves and restores return PCs for interrupt and debug entry and exit. Sits between the execute/CSR logic, which supplies redirects and returns, and the instruction fetch unit, which consumes `pc_o`.

## Interface
Parameters:
- `PC_STEP`, 4: byte increment for sequential fetch.

Ports:
- `clk_i`  in  1  system clock; all state updates on its rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `stall_i`  in  1  fetch not ready; holds `pc_o`; redirect inputs are not sampled.
- `branch_i`  in  1  taken branch or jump this cycle.
- `branch_target_i`  in  32  branch destination.
- `irq_i`  in  1  level interrupt request.
- `mret_i`  in  1  return from interrupt handler.
- `drq_i`  in  1  level debug request.
- `dret_i`  in  1  return from debug handler.
- `pc_o`  out  32  current fetch PC.
- `pc_valid_o`  out  1  `pc_o` is issuable.
- `irq_ack_o`  out  1  one-cycle pulse when an interrupt redirect is taken.
- `drq_ack_o`  out  1  one-cycle pulse when a debug redirect is taken.
- `epc_o`  out  32  saved interrupt return PC.
- `dpc_o`  out  32  saved debug return PC.

## Operation
- States: `RESET`, `RUN`, `IRQ`, `DEBUG`. `IRQ` and `DEBUG` fetch normally; they only mask further requests.
- `RESET`: entered on any cycle with `rst_i`=1, including mid-operation. First edge with `rst_i`=0 -> `RUN` with `pc_o`=boot_address (0x00000000) and `pc_valid_o`=1.
- Advance cycle: `pc_valid_o`=1 and `stall_i`=0. Only advance cycles sample `branch_i`, `mret_i`, `dret_i`, `irq_i` and `drq_i`. Upstream holds these signals across stalls.
- Sequential next PC is `seq` = `branch_target_i` if `branch_i`, else `pc_o`+`PC_STEP`. Addition wraps modulo 2^32. No alignment check is made; interrupt_address 0x0000000A is issued as-is.
- Priority on an advance cycle is `dret_i` > `drq_i` > `mret_i` > `irq_i` > `seq`:
  - `dret_i` in `DEBUG`: `pc_o`<=`dpc_o`; return to the state saved on debug entry.
  - `drq_i` outside `DEBUG`: `dpc_o`<=`seq`; save the current state (`RUN` or `IRQ`); `pc_o`<=debug_address (0x0000000B); pulse `drq_ack_o`; -> `DEBUG`.
  - `mret_i` in `IRQ`: `pc_o`<=`epc_o`; -> `RUN`.
  - `irq_i` in `RUN` only: `epc_o`<=`seq`; `pc_o`<=interrupt_address; pulse `irq_ack_o`; -> `IRQ`.
- Interrupts are masked in `IRQ` and `DEBUG`. Debug requests are masked in `DEBUG`. A pending `irq_i` is taken on the first advance cycle after masking clears.
- `mret_i` outside `IRQ` and `dret_i` outside `DEBUG` are ignored; the sequencer takes `seq`.

## Timing
- Reset values: `pc_o`=0x00000000, `pc_valid_o`=0, `irq_ack_o`=0, `drq_ack_o`=0, `epc_o`=0, `dpc_o`=0, state `RESET`.
- All outputs are registered. A redirect sampled on cycle N appears on `pc_o` at cycle N+1. Ack pulses are asserted in cycle N+1 for exactly one cycle.
- `stall_i`=1: `pc_o`, `epc_o`, `dpc_o` and state are held; acks are 0.
- `pc_valid_o` is 0 only in `RESET`.

## Configuration
- `ECAP5_DPROC_DEBUG_EN` defined: debug behaviour is exactly as described above.
- Not defined: the `DEBUG` state and the saved-state register are removed. `drq_i` and `dret_i` remain as ports but are ignored. `drq_ack_o`=0 and `dpc_o`=0 constantly.

## Structure
- The shared package `ecap5_dproc_pkg` keeps boot_address, interrupt_address and debug_address. Add `pc_seq_state_t`, the 2-bit enum of the four states, so trace/debug logic can decode it.
- Single flat module. The next-PC mux and the state machine are too small to justify a sub-module.

## Test plan
- Hold `rst_i`=1 for 3 cycles, then release -> `pc_valid_o`=0 during reset. First valid `pc_o`=0x0, then 0x4, then 0x8.
- `branch_i`=1 with target 0x100 while `pc_o`=0x8 -> `pc_o`=0x100, then 0x104.
- `irq_i`=1 at `pc_o`=0x104 -> `pc_o`=0xA, `irq_ack_o` pulse, `epc_o`=0x108. Hold `irq_i` -> no further ack. `mret_i` -> `pc_o`=0x108, then the interrupt is re-taken if `irq_i` is still high.
- `drq_i` and `branch_i` (target 0x200) and `irq_i` asserted together in `RUN` -> `pc_o`=0xB, `dpc_o`=0x200, no `irq_ack_o`. `dret_i` -> `pc_o`=0x200, then the irq is taken.
- `stall_i`=1 for 3 cycles with `branch_i` asserted at `pc_o`=0x20 -> `pc_o` holds 0x20. On release -> branch target.
- `rst_i` pulsed while in `IRQ` -> all reset values on the next cycle, then boot at 0x0. With `ECAP5_DPROC_DEBUG_EN` undefined, `drq_i`=1 -> sequential PC continues, `drq_ack_o`=0.
